bcd_chain_counter: RTL and testbench



---
 rtl/bcd_counter_pkg.sv | 15 +
 rtl/bcd_digit_cell.sv | 48 ++++
 rtl/bcd_chain_counter.sv | 93 +++++++++
 tb/tb_bcd_chain_counter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared constants and helpers for the BCD counter chain and its digit cells.
package bcd_counter_pkg;

    // Every digit is held and computed as a 4-bit BCD nibble.
    localparam int DIGIT_W = 4;

    // Default chain modulus for an mm:ss display: {6,10,6,10}, digit 0 in the low nibble.
    localparam logic [15:0] DEFAULT_DIGIT_MOD = 16'h6A6A;

    // Largest legal value of a digit whose modulus is mod.
    function automatic logic [DIGIT_W-1:0] digit_max(input int mod);
        return DIGIT_W'(mod - 1);
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One digit of the BCD chain: clamped preset load, and an up or down step with wrap at its modulus.
module bcd_digit_cell
    import bcd_counter_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step_in,
    input  logic               up_down,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] digit,
    output logic               at_max,
    output logic               at_zero
);

    localparam logic [DIGIT_W-1:0] MaxValue = digit_max(MOD);

    logic [DIGIT_W-1:0] nextDigit;

    assign at_max  = (digit == MaxValue);
    assign at_zero = (digit == '0);

    // Next digit value: load (clamped to the digit's maximum) beats a step, otherwise hold.
    always_comb begin
        nextDigit = digit;
        if (load) begin
            nextDigit = (load_digit > MaxValue) ? MaxValue : load_digit;
        end else if (step_in) begin
            if (up_down) begin
                nextDigit = at_max ? '0 : digit + 4'd1;
            end else begin
                nextDigit = at_zero ? MaxValue : digit - 4'd1;
            end
        end
    end

    // Digit register with synchronous reset to zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            digit <= '0;
        end else begin
            digit <= nextDigit;
        end
    end

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit BCD counter chain with per-digit modulus, up/down, wrap-or-saturate, preset load and lap capture.
module bcd_chain_counter
    import bcd_counter_pkg::*;
#(
    parameter int          NUM_DIGITS = 4,
    parameter logic [15:0] DIGIT_MOD  = DEFAULT_DIGIT_MOD
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          wrap_en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    input  logic                          lap,
    input  logic                          lap_clear,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic [DIGIT_W*NUM_DIGITS-1:0] lap_count,
    output logic                          lap_valid,
    output logic                          tc,
    output logic                          overflow
);

    logic [NUM_DIGITS-1:0] atMax;
    logic [NUM_DIGITS-1:0] atZero;
    logic [NUM_DIGITS-1:0] carryIn;
    logic [NUM_DIGITS-1:0] borrowIn;
    logic [NUM_DIGITS-1:0] stepIn;
    logic                  carryAcc;
    logic                  borrowAcc;
    logic                  terminalEvent;
    logic                  holdAtTerminal;

    // Terminal detection for the current direction; a terminal tick in saturate mode freezes the chain.
    assign tc             = up_down ? (&atMax) : (&atZero);
    assign terminalEvent  = enable & tc & ~load;
    assign holdAtTerminal = terminalEvent & ~wrap_en;

    // Ripple carry and borrow: a digit steps only when every lower digit sits at its max (up) or zero (down).
    always_comb begin
        carryAcc  = enable;
        borrowAcc = enable;
        carryIn   = '0;
        borrowIn  = '0;
        stepIn    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            carryIn[i]  = carryAcc;
            borrowIn[i] = borrowAcc;
            stepIn[i]   = (up_down ? carryAcc : borrowAcc) & ~holdAtTerminal;
            carryAcc    = carryAcc & atMax[i];
            borrowAcc   = borrowAcc & atZero[i];
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
        bcd_digit_cell #(
            .MOD(int'(DIGIT_MOD[DIGIT_W*i +: DIGIT_W]))
        ) uCell (
            .clock     (clock),
            .reset     (reset),
            .step_in   (stepIn[i]),
            .up_down   (up_down),
            .load      (load),
            .load_digit(load_value[DIGIT_W*i +: DIGIT_W]),
            .digit     (count[DIGIT_W*i +: DIGIT_W]),
            .at_max    (atMax[i]),
            .at_zero   (atZero[i])
        );
    end

    // Overflow is a one-cycle pulse in the cycle after each terminal tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= terminalEvent;
        end
    end

    // Lap register captures the pre-update count; a capture beats a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            lap_count <= '0;
            lap_valid <= 1'b0;
        end else if (lap) begin
            lap_count <= count;
            lap_valid <= 1'b1;
        end else if (lap_clear) begin
            lap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_chain_counter.sv
// Directed self-checking bench for the mm:ss BCD counter chain.
module tb_bcd_chain_counter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        up_down;
    logic        wrap_en;
    logic        load;
    logic [15:0] load_value;
    logic        lap;
    logic        lap_clear;
    logic [15:0] count;
    logic [15:0] lap_count;
    logic        lap_valid;
    logic        tc;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    bcd_chain_counter dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .up_down   (up_down),
        .wrap_en   (wrap_en),
        .load      (load),
        .load_value(load_value),
        .lap       (lap),
        .lap_clear (lap_clear),
        .count     (count),
        .lap_count (lap_count),
        .lap_valid (lap_valid),
        .tc        (tc),
        .overflow  (overflow)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hold strobes for exactly one rising edge, then release them 1 ns after that edge.
    task automatic applyStimulus(input logic rst, input logic en, input logic ld,
                                 input logic [15:0] lv, input logic lp, input logic lc);
        reset      = rst;
        enable     = en;
        load       = ld;
        load_value = lv;
        lap        = lp;
        lap_clear  = lc;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        lap       = 1'b0;
        lap_clear = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        up_down    = 1'b1;
        wrap_en    = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;
        lap        = 1'b0;
        lap_clear  = 1'b0;
        @(posedge clock);
        #1;

        // Reset values
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("reset_count", count, 16'h0000);
        checkOutput("reset_lap_count", lap_count, 16'h0000);
        checkOutput("reset_lap_valid", 16'(lap_valid), 16'h0000);
        checkOutput("reset_overflow", 16'(overflow), 16'h0000);
        checkOutput("reset_tc_up", 16'(tc), 16'h0000);
        up_down = 1'b0;
        #1;
        checkOutput("reset_tc_down", 16'(tc), 16'h0001);
        up_down = 1'b1;

        // Scenario 1: 60 up-counts across the mod-10 / mod-6 boundary
        for (int i = 0; i < 59; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        end
        checkOutput("s1_count_59", count, 16'h0059);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s1_count_60", count, 16'h0100);
        checkOutput("s1_no_overflow", 16'(overflow), 16'h0000);

        // Scenario 2: wrap at 59:59
        wrap_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5958, 1'b0, 1'b0);
        checkOutput("s2_load", count, 16'h5958);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s2_count_5959", count, 16'h5959);
        checkOutput("s2_tc", 16'(tc), 16'h0001);
        checkOutput("s2_ovf_before", 16'(overflow), 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s2_count_wrap", count, 16'h0000);
        checkOutput("s2_ovf_pulse", 16'(overflow), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s2_ovf_end", 16'(overflow), 16'h0000);

        // Scenario 3: saturate at 59:59
        wrap_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5958, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s3_count_5959", count, 16'h5959);
        checkOutput("s3_ovf_before", 16'(overflow), 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s3_hold_1", count, 16'h5959);
        checkOutput("s3_ovf_1", 16'(overflow), 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s3_hold_2", count, 16'h5959);
        checkOutput("s3_ovf_2", 16'(overflow), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s3_ovf_end", 16'(overflow), 16'h0000);

        // Scenario 4: down-counting, borrow and down-wrap
        up_down = 1'b0;
        wrap_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s4_borrow", count, 16'h0059);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("s4_tc_zero", 16'(tc), 16'h0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s4_down_wrap", count, 16'h5959);
        checkOutput("s4_ovf", 16'(overflow), 16'h0001);
        wrap_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("s4_down_sat", count, 16'h0000);
        checkOutput("s4_down_sat_ovf", 16'(overflow), 16'h0001);

        // Scenario 5: load clamping and load priority over enable
        up_down = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("s5_clamp_ffff", count, 16'h5959);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h7A3C, 1'b0, 1'b0);
        checkOutput("s5_clamp_mixed", count, 16'h5939);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5959, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("s5_load_wins", count, 16'h1234);
        checkOutput("s5_load_no_ovf", 16'(overflow), 16'h0000);

        // Scenario 6: lap capture, clear, capture-beats-clear, and reset abort
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0012, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("s6_lap_count", lap_count, 16'h0012);
        checkOutput("s6_count", count, 16'h0013);
        checkOutput("s6_lap_valid", 16'(lap_valid), 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("s6_clear_valid", 16'(lap_valid), 16'h0000);
        checkOutput("s6_clear_keeps", lap_count, 16'h0012);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("s6_lap_beats_clear", 16'(lap_valid), 16'h0001);
        checkOutput("s6_lap_count_2", lap_count, 16'h0013);
        wrap_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5959, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("s6_reset_count", count, 16'h0000);
        checkOutput("s6_reset_lap_count", lap_count, 16'h0000);
        checkOutput("s6_reset_lap_valid", 16'(lap_valid), 16'h0000);
        checkOutput("s6_reset_overflow", 16'(overflow), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
